led_share_arbiter: RTL and testbench
====================================

Name: led_share_arbiter

Overview:
Round-robin arbiter that shares the board's BITS-wide LED bank between NREQ requesters, each presenting a value to display. A free-running prescaler, clocked from the on-chip HF oscillator domain, generates slow ticks. Each granted requester owns the LEDs for HOLD_TICKS ticks, then receives a one-cycle acknowledge. The block sits between the status/counter producers and the LED pins in the top level.

Parameters:
NREQ, 4, number of requesters (2..8)
BITS, 4, LED/value width
LOG2DELAY, 22, prescaler width; one tick every 2^LOG2DELAY clk cycles
HOLD_TICKS, 2, ticks per grant; must be >= 1
PWM_BITS, 4, PWM counter width (used only with the optional feature)

Ports:
clk  in  1  single clock (HF oscillator output)
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  request i asserted, level-held by requester
req_value  in  NREQ*BITS  value of requester i at [i*BITS +: BITS]
pwm_duty  in  PWM_BITS  brightness duty; present only with the optional feature
grant  out  NREQ  one-hot owner of the LEDs, 0 when idle
req_ack  out  NREQ  one-cycle pulse to requester i on normal completion
busy  out  1  high while any grant is active
leds  out  BITS  drives LED pins

Behaviour:
- Reset, synchronous and active-high, sampled on posedge clk:
  - state=IDLE; grant=0, req_ack=0, busy=0, leds=0.
  - Prescaler=0, tick counter=0, pointer last=NREQ-1, so requester 0 has first priority.
  - Reset mid-grant aborts the grant with no ack.
- Prescaler: free-running LOG2DELAY-bit up-counter that wraps. tick=1 in the cycle the count is all-ones. It is not restarted by grants.
- States:
  - IDLE: if any req_valid, pick the first valid index scanning last+1, last+2, … mod NREQ. At that edge: grant<=onehot(winner), shown<=req_value[winner], tick_cnt<=0, state<=HOLD. With no request, stay in IDLE.
  - HOLD, normal completion: on each tick, tick_cnt increments. On the tick where tick_cnt==HOLD_TICKS-1, at that edge: req_ack[winner]<=1 for exactly one cycle, grant<=0, shown<=0, last<=winner, state<=IDLE.
  - HOLD, requester drop: if req_valid[winner] drops, then at the next edge grant<=0, shown<=0, last<=winner, state<=IDLE, and no ack is issued. If the drop coincides with the final tick, the abort wins and no ack is issued.
- Latency:
  - Request seen in IDLE at cycle t → grant and leds valid at t+1.
  - Hold length is between (HOLD_TICKS-1)*2^LOG2DELAY+1 and HOLD_TICKS*2^LOG2DELAY cycles.
  - After ack or abort the block spends at least one cycle in IDLE before the next grant.
- Value latching: shown is captured at grant. req_value changes during HOLD are ignored.
- Re-request: a requester still valid in the cycle after its ack is a new request. It now has lowest priority, which gives fairness.
- Outputs: busy = (state==HOLD). All outputs are registered. Without the optional feature, leds = shown.
- Simultaneous requests: only the round-robin winner is granted. Other requests stay pending, with no drop or ack, until they win.

Optional Feature:
Macro LED_SHARE_PWM_EN.
- Defined:
  - pwm_duty port exists.
  - A free-running PWM_BITS counter pwm_cnt (reset 0) runs alongside the prescaler.
  - leds = shown & {BITS{pwm_cnt < pwm_duty}}, registered.
  - duty 0 gives LEDs fully off; duty 2^PWM_BITS-1 gives on for 15/16 of cycles (PWM_BITS=4).
- Undefined: no pwm_duty port and no PWM counter; leds = shown.

Test Plan:
All cases use NREQ=4, BITS=4, LOG2DELAY=3, HOLD_TICKS=2.
1. Reset: hold rst 2 cycles with all requests valid → grant=0, leds=0, req_ack=0, busy=0. First grant after release goes to req0.
2. Single request: req_valid=0b0100, value2=4'hA → grant=0b0100 and leds=4'hA one cycle later. Ack pulses on req_ack[2] 9..16 cycles after grant. Then leds=0 and busy=0.
3. Round-robin: all four valid continuously with values 1,2,3,4 → grants in order 0,1,2,3,0. Each grant ends with a single-cycle ack, and idle gaps are ≥1 cycle.
4. Abort: drop req_valid[1] mid-HOLD → grant cleared next cycle, no req_ack[1]. The next grant goes to req2 if valid.
5. Value latching: change req_value[0] from 4'h5 to 4'hF during HOLD → leds stays 4'h5 until release.
6. Reset mid-grant, plus PWM with LED_SHARE_PWM_EN:
   - Assert rst during HOLD → no ack and all outputs 0 next cycle.
   - With pwm_duty=4, value 4'hF → leds=4'hF for exactly 4 of every 16 cycles.

Source files
------------

// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin owner of a shared LED bank.
// Each winner displays its latched value for HOLD_TICKS prescaler ticks,
// then gets a one-cycle acknowledge. Dropping the request aborts the grant
// early with no acknowledge.
// Optional macro LED_SHARE_PWM_EN adds a pwm_duty port and a brightness
// PWM on the LED outputs.
module led_share_arbiter #(
   parameter int NREQ       = 4,
   parameter int BITS       = 4,
   parameter int LOG2DELAY  = 22,
`ifdef LED_SHARE_PWM_EN
   parameter int HOLD_TICKS = 2,
   parameter int PWM_BITS   = 4
`else
   parameter int HOLD_TICKS = 2
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*BITS-1:0] req_value,
`ifdef LED_SHARE_PWM_EN
   input  logic [PWM_BITS-1:0]  pwm_duty,
`endif
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      req_ack,
   output logic                 busy,
   output logic [BITS-1:0]      leds
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state;
   logic [LOG2DELAY-1:0] presc;
   logic                tick;
   logic [TW-1:0]       tick_cnt;
   logic [IW-1:0]       last;
   logic [IW-1:0]       owner;
   logic [BITS-1:0]     shown;

   logic                found;
   logic [IW-1:0]       win;
   logic [BITS-1:0]     win_value;

   // Free-running prescaler; grants never restart it, so hold length jitters by up to one tick period.
   always_ff @(posedge clk) begin
      if (rst) presc <= '0;
      else     presc <= presc + 1'b1;
   end

   assign tick = &presc;

   // Round-robin search starting just after the last owner, so the last owner has lowest priority.
   always_comb begin
      logic [IW-1:0] cand;
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Value of the prospective winner, captured into shown at grant time.
   always_comb begin
      win_value = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IW'(i)) win_value = req_value[i*BITS +: BITS];
      end
   end

   // Grant FSM: IDLE picks a winner, HOLD counts ticks and ends with ack or abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         req_ack  <= '0;
         busy     <= 1'b0;
         shown    <= '0;
         tick_cnt <= '0;
         owner    <= '0;
         last     <= IW'(NREQ - 1);
      end else begin
         req_ack <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  grant    <= NREQ'(1) << win;
                  owner    <= win;
                  shown    <= win_value;
                  tick_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               // An abort takes precedence over a coincident final tick.
               if (!req_valid[owner]) begin
                  grant <= '0;
                  shown <= '0;
                  busy  <= 1'b0;
                  last  <= owner;
                  state <= IDLE;
               end else if (tick) begin
                  if (tick_cnt == TW'(HOLD_TICKS - 1)) begin
                     req_ack <= grant;
                     grant   <= '0;
                     shown   <= '0;
                     busy    <= 1'b0;
                     last    <= owner;
                     state   <= IDLE;
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LED_SHARE_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt;

   // Brightness PWM: LEDs show the latched value only while pwm_cnt is below the duty.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt <= '0;
         leds    <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         leds    <= shown & {BITS{pwm_cnt < pwm_duty}};
      end
   end
`else
   assign leds = shown;
`endif

endmodule

// File: tb/tb_led_share_arbiter.sv
// Testbench for led_share_arbiter (NREQ=4, BITS=4, LOG2DELAY=3, HOLD_TICKS=2).
// Define LED_SHARE_PWM_EN for both files to exercise the PWM build.
module tb_led_share_arbiter;

   localparam int NREQ = 4;
   localparam int BITS = 4;
   localparam int HOLD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [15:0] req_value = '0;
   logic [3:0]  grant, req_ack, leds;
   logic        busy;
`ifdef LED_SHARE_PWM_EN
   logic [3:0]  pwm_duty = 4'd4;
`endif

   led_share_arbiter #(
      .NREQ(NREQ), .BITS(BITS), .LOG2DELAY(3),
`ifdef LED_SHARE_PWM_EN
      .HOLD_TICKS(HOLD), .PWM_BITS(4)
`else
      .HOLD_TICKS(HOLD)
`endif
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_value(req_value),
`ifdef LED_SHARE_PWM_EN
      .pwm_duty(pwm_duty),
`endif
      .grant(grant), .req_ack(req_ack), .busy(busy), .leds(leds)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: owner index (-1 when idle), ticks seen, last owner, cycles since reset.
   int         m_own  = -1;
   int         m_ticks = 0;
   int         m_last = 3;
   int         pc = 0;
   logic [3:0] m_shown = '0;
   logic [3:0] m_leds = '0;
   logic [3:0] m_ack = '0;

   logic [12:0] act;
   assign act = {grant, req_ack, busy, leds};

   function automatic logic [12:0] expv();
      logic [3:0] g;
      g = (m_own < 0) ? 4'd0 : (4'd1 << m_own);
      return {g, m_ack, (m_own >= 0), m_leds};
   endfunction

   task automatic model_step();
      logic tk;
`ifdef LED_SHARE_PWM_EN
      logic [3:0] sh_old;
      int pc_old;
`endif
      if (rst) begin
         m_own = -1; m_ticks = 0; m_last = 3; m_shown = '0;
         m_leds = '0; m_ack = '0; pc = 0;
         return;
      end
      tk = ((pc % 8) == 7);
`ifdef LED_SHARE_PWM_EN
      pc_old = pc;
      sh_old = m_shown;
`endif
      pc++;
      m_ack = '0;
      if (m_own < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) begin
               m_own = idx;
               m_shown = req_value[idx*4 +: 4];
               m_ticks = 0;
               break;
            end
         end
      end else if (!req_valid[m_own]) begin
         m_last = m_own; m_own = -1; m_shown = '0;
      end else if (tk) begin
         m_ticks++;
         if (m_ticks == HOLD) begin
            m_ack = 4'd1 << m_own;
            m_last = m_own; m_own = -1; m_shown = '0;
         end
      end
`ifdef LED_SHARE_PWM_EN
      m_leds = ((pc_old % 16) < int'(pwm_duty)) ? sh_old : 4'd0;
`else
      m_leds = m_shown;
`endif
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req_valid = 4'hF;
      req_value = 16'h4321;
      rst = 1'b1;
      repeat (2) begin
         cyc();
         n_cmp++;
         if (act !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h exp=%h", act, 13'd0);
         end
      end
      rst = 1'b0;
      cyc();
      n_cmp++;
      if (grant !== 4'b0001) begin
         n_bad++;
         $display("FAIL reset_first_grant got=%b exp=0001", grant);
      end
      n_cmp++;
      if (act !== expv()) begin
         n_bad++;
         $display("FAIL reset_model got=%h exp=%h", act, expv());
      end
   endtask

   task automatic test_single();
      int got;
      req_valid = 4'b0000;
      cyc();
      cyc();
      req_valid = 4'b0100;
      req_value = 16'h0A00;
      cyc();
      n_cmp++;
      if (grant !== 4'b0100 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL single_grant got=%b/%b exp=0100/1", grant, busy);
      end
`ifndef LED_SHARE_PWM_EN
      n_cmp++;
      if (leds !== 4'hA) begin
         n_bad++;
         $display("FAIL single_leds got=%h exp=a", leds);
      end
`endif
      got = -1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         n_cmp++;
         if (act !== expv()) begin
            n_bad++;
            $display("FAIL single_model cyc=%0d got=%h exp=%h", i, act, expv());
         end
         if (req_ack[2] === 1'b1) begin
            got = i;
            break;
         end
      end
      n_cmp++;
      if (got < 9 || got > 16) begin
         n_bad++;
         $display("FAIL single_ack_latency got=%0d exp=9..16", got);
      end
      n_cmp++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL single_release got=%b/%b exp=0000/0", grant, busy);
      end
`ifndef LED_SHARE_PWM_EN
      n_cmp++;
      if (leds !== 4'h0) begin
         n_bad++;
         $display("FAIL single_release_leds got=%h exp=0", leds);
      end
`endif
      req_valid = 4'b0000;
      cyc();
   endtask

   task automatic test_round_robin();
      int q[$];
      logic [3:0] prevg, preva;
      req_valid = 4'hF;
      req_value = 16'h4321;
      do_reset();
      prevg = '0;
      preva = '0;
      for (int i = 0; i < 200 && q.size() < 5; i++) begin
         cyc();
         n_cmp++;
         if (act !== expv()) begin
            n_bad++;
            $display("FAIL rr_model cyc=%0d got=%h exp=%h", i, act, expv());
         end
         if (grant != 4'd0 && prevg == 4'd0) q.push_back($clog2(grant));
         if (preva != 4'd0 && req_ack != 4'd0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr_ack_width got=%b after %b exp=0000", req_ack, preva);
         end
         prevg = grant;
         preva = req_ack;
      end
      n_cmp++;
      if (q.size() != 5) begin
         n_bad++;
         $display("FAIL rr_grant_count got=%0d exp=5", q.size());
      end else begin
         for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (q[j] != j % 4) begin
               n_bad++;
               $display("FAIL rr_order idx=%0d got=%0d exp=%0d", j, q[j], j % 4);
            end
         end
      end
      req_valid = 4'b0000;
      cyc();
   endtask

   task automatic test_abort();
      req_valid = 4'b0110;
      req_value = 16'h0CB0;
      do_reset();
      cyc();
      n_cmp++;
      if (grant !== 4'b0010) begin
         n_bad++;
         $display("FAIL abort_first_grant got=%b exp=0010", grant);
      end
      repeat ($urandom_range(1, 6)) cyc();
      req_valid = 4'b0100;
      cyc();
      n_cmp++;
      if (grant !== 4'b0000 || req_ack !== 4'b0000) begin
         n_bad++;
         $display("FAIL abort_clear got=%b/%b exp=0000/0000", grant, req_ack);
      end
      cyc();
      n_cmp++;
      if (grant !== 4'b0100 || act !== expv()) begin
         n_bad++;
         $display("FAIL abort_next_grant got=%h exp=%h", act, expv());
      end
      req_valid = 4'b0000;
      cyc();
   endtask

   task automatic test_latch();
      bool_done: begin end
      req_valid = 4'b0001;
      req_value = 16'h0005;
      do_reset();
      cyc();
      req_value = 16'h000F;
      for (int i = 0; i < 20; i++) begin
         cyc();
         n_cmp++;
         if (act !== expv()) begin
            n_bad++;
            $display("FAIL latch_model cyc=%0d got=%h exp=%h", i, act, expv());
         end
`ifndef LED_SHARE_PWM_EN
         if (busy) begin
            n_cmp++;
            if (leds !== 4'h5) begin
               n_bad++;
               $display("FAIL latch_leds got=%h exp=5", leds);
            end
         end
`endif
         if (!busy) break;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL latch_timeout busy=%b exp=0", busy);
      end
      req_valid = 4'b0000;
      cyc();
   endtask

   task automatic test_reset_mid();
      req_valid = 4'b1000;
      req_value = 16'h7000;
      do_reset();
      cyc();
      repeat ($urandom_range(2, 6)) cyc();
      rst = 1'b1;
      cyc();
      n_cmp++;
      if (act !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_mid got=%h exp=%h", act, 13'd0);
      end
      rst = 1'b0;
      req_valid = 4'b0000;
      cyc();
      n_cmp++;
      if (req_ack !== 4'b0000 || act !== expv()) begin
         n_bad++;
         $display("FAIL reset_mid_after got=%h exp=%h", act, expv());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) req_valid = 4'($urandom);
         req_value = 16'($urandom);
`ifdef LED_SHARE_PWM_EN
         if ($urandom_range(0, 31) == 0) pwm_duty = 4'($urandom);
`endif
         rst = ($urandom_range(0, 199) == 0);
         cyc();
         n_cmp++;
         if (act !== expv()) begin
            n_bad++;
            $display("FAIL random_model cyc=%0d got=%h exp=%h", i, act, expv());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_abort();
      test_latch();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
